// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: master IDs and transfer size encodings shared by the arbiter slice
package sram_arb_pkg;
    localparam logic       ID_INST = 1'b0;
    localparam logic       ID_DATA = 1'b1;
    localparam logic [1:0] SIZE_B  = 2'd0;
    localparam logic [1:0] SIZE_H  = 2'd1;
    localparam logic [1:0] SIZE_W  = 2'd2;
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: SRAM-like request/response port; master issues, slave accepts and returns
interface sram_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_arbiter_id_fifo.sv
// id_fifo: in-order queue of 1-bit master IDs for accepted-but-unreturned requests
module id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    rd, wr;
    logic [AW:0]      count;
    logic             do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rd];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr] <= din;
                wr      <= wr + AW'(1);
            end
            if (do_pop) rd <= rd + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like port between inst and data masters, data first, in-order returns
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int OST_DEPTH = 2
) (
    input  logic           clk,
    input  logic           resetn,
    sram_arbiter_if.slave  inst_sram,
    sram_arbiter_if.slave  data_sram,
    sram_arbiter_if.master mem
);
    logic lock_valid, lock_id, grant_id, grant_req, accept, full, empty, head, is_data;
    assign grant_id  = lock_valid ? lock_id : (data_sram.req ? ID_DATA : ID_INST);
    assign is_data   = grant_id == ID_DATA;
    assign grant_req = is_data ? data_sram.req : inst_sram.req;
    assign mem.req   = grant_req & ~full & resetn;
    assign mem.wr    = is_data ? data_sram.wr    : inst_sram.wr;
    assign mem.size  = is_data ? data_sram.size  : inst_sram.size;
    assign mem.wstrb = is_data ? data_sram.wstrb : inst_sram.wstrb;
    assign mem.addr  = is_data ? data_sram.addr  : inst_sram.addr;
    assign mem.wdata = is_data ? data_sram.wdata : inst_sram.wdata;
    assign accept            = mem.req & mem.addr_ok;
    assign inst_sram.addr_ok = accept & ~is_data;
    assign data_sram.addr_ok = accept & is_data;
    // Responses come back in acceptance order, so the FIFO head names the owner
    assign inst_sram.data_ok = mem.data_ok & resetn & ~empty & (head == ID_INST);
    assign data_sram.data_ok = mem.data_ok & resetn & ~empty & (head == ID_DATA);
    assign inst_sram.rdata   = mem.rdata;
    assign data_sram.rdata   = mem.rdata;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_valid <= 1'b0;
            lock_id    <= ID_INST;
        end else if (accept) begin
            lock_valid <= 1'b0;
        end else if (mem.req) begin
            lock_valid <= 1'b1;
            lock_id    <= grant_id;
        end else if (!grant_req) begin
            lock_valid <= 1'b0;
        end
    end
    id_fifo #(.DEPTH(OST_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (mem.data_ok),
        .din    (grant_id),
        .full   (full),
        .empty  (empty),
        .head   (head)
    );
    a_lock_held: assert property (@(posedge clk) disable iff (!resetn) lock_valid |-> grant_req)
        else $warning("locked master withdrew its request");
    a_no_stray: assert property (@(posedge clk) disable iff (!resetn) mem.data_ok |-> !empty)
        else $warning("mem_data_ok with no outstanding request dropped");
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus, queue-based reference model checked every cycle plus literal pins
module tb_sram_arbiter;
    import sram_arb_pkg::*;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic resetn;
    int   pass = 0, total = 0;
    bit   q[$];
    bit   lk, lo, g, greq, er, hv, hd;
    sram_arbiter_if inst_if ();
    sram_arbiter_if data_if ();
    sram_arbiter_if mem_if ();

    sram_arbiter #(.OST_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .inst_sram (inst_if.slave),
        .data_sram (data_if.slave),
        .mem       (mem_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) pass++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    // Reference model: outstanding owners in a queue, a pending-but-unaccepted owner held sticky
    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_mem_req", mem_if.req, 0);
            chk("rst_inst_addr_ok", inst_if.addr_ok, 0);
            chk("rst_data_addr_ok", data_if.addr_ok, 0);
            chk("rst_inst_data_ok", inst_if.data_ok, 0);
            chk("rst_data_data_ok", data_if.data_ok, 0);
            q.delete();
            lk = 0;
        end else begin
            g    = lk ? lo : data_if.req;
            greq = g ? data_if.req : inst_if.req;
            er   = greq && q.size() < DEPTH;
            hv   = q.size() > 0;
            hd   = hv ? q[0] : 1'b0;
            chk("m_mem_req", mem_if.req, er);
            if (er) begin
                chk("m_addr",  mem_if.addr,  g ? data_if.addr  : inst_if.addr);
                chk("m_wr",    mem_if.wr,    g ? data_if.wr    : inst_if.wr);
                chk("m_size",  mem_if.size,  g ? data_if.size  : inst_if.size);
                chk("m_wstrb", mem_if.wstrb, g ? data_if.wstrb : inst_if.wstrb);
                chk("m_wdata", mem_if.wdata, g ? data_if.wdata : inst_if.wdata);
            end
            chk("m_inst_addr_ok", inst_if.addr_ok, er && mem_if.addr_ok && !g);
            chk("m_data_addr_ok", data_if.addr_ok, er && mem_if.addr_ok && g);
            chk("m_inst_data_ok", inst_if.data_ok, mem_if.data_ok && hv && !hd);
            chk("m_data_data_ok", data_if.data_ok, mem_if.data_ok && hv && hd);
            if (mem_if.data_ok && hv) begin
                chk("m_inst_rdata", inst_if.rdata, mem_if.rdata);
                chk("m_data_rdata", data_if.rdata, mem_if.rdata);
            end
            if (mem_if.data_ok && hv) void'(q.pop_front());
            if (er && mem_if.addr_ok) begin
                q.push_back(g);
                lk = 0;
            end else if (er) begin
                lk = 1;
                lo = g;
            end else lk = 0;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit ir, input bit dr, input bit aok, input bit dok);
        inst_if.req    = ir;
        data_if.req    = dr;
        mem_if.addr_ok = aok;
        mem_if.data_ok = dok;
    endtask

    initial begin
        resetn = 0;
        inst_if.wr = 0; inst_if.size = SIZE_W; inst_if.wstrb = 4'h0;
        inst_if.addr = 32'h1C00_0000; inst_if.wdata = 32'h0;
        data_if.wr = 0; data_if.size = SIZE_W; data_if.wstrb = 4'h0;
        data_if.addr = 32'h0000_1000; data_if.wdata = 32'h0;
        mem_if.rdata = 32'h0;
        drv(1, 1, 1, 1);
        @(negedge clk);
        chk("reset_mem_req", mem_if.req, 0);
        chk("reset_inst_addr_ok", inst_if.addr_ok, 0);
        nxt();
        resetn = 1;
        drv(0, 0, 0, 0);
        nxt();

        // single read
        drv(1, 0, 0, 0);
        @(negedge clk);
        chk("sr_req", mem_if.req, 1);
        chk("sr_addr", mem_if.addr, 32'h1C00_0000);
        chk("sr_aok_wait", inst_if.addr_ok, 0);
        nxt();
        drv(1, 0, 1, 0);
        @(negedge clk);
        chk("sr_aok", inst_if.addr_ok, 1);
        nxt();
        drv(0, 0, 0, 0);
        nxt();
        drv(0, 0, 0, 1);
        mem_if.rdata = 32'h0280_0000;
        @(negedge clk);
        chk("sr_dok", inst_if.data_ok, 1);
        chk("sr_rdata", inst_if.rdata, 32'h0280_0000);
        chk("sr_data_dok", data_if.data_ok, 0);
        nxt();

        // priority and lock
        drv(1, 0, 0, 0);
        inst_if.addr = 32'h1C00_0040;
        nxt();
        drv(1, 1, 0, 0);
        data_if.wr = 1; data_if.wstrb = 4'hF; data_if.addr = 32'h0000_2000; data_if.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("pl_locked_addr", mem_if.addr, 32'h1C00_0040);
        chk("pl_locked_wr", mem_if.wr, 0);
        nxt();
        drv(1, 1, 1, 0);
        @(negedge clk);
        chk("pl_inst_aok", inst_if.addr_ok, 1);
        chk("pl_data_aok", data_if.addr_ok, 0);
        nxt();
        drv(0, 1, 1, 0);
        @(negedge clk);
        chk("pl_data_addr", mem_if.addr, 32'h0000_2000);
        chk("pl_data_wr", mem_if.wr, 1);
        chk("pl_data_wstrb", mem_if.wstrb, 4'hF);
        chk("pl_data_aok2", data_if.addr_ok, 1);
        nxt();
        drv(0, 0, 0, 1);
        @(negedge clk);
        chk("pl_ret_inst", inst_if.data_ok, 1);
        nxt();
        @(negedge clk);
        chk("pl_ret_data", data_if.data_ok, 1);
        nxt();
        drv(0, 0, 0, 0);
        data_if.wr = 0; data_if.wstrb = 4'h0;
        nxt();

        // simultaneous requests
        inst_if.addr = 32'h1C00_0080; data_if.addr = 32'h0000_3000;
        drv(1, 1, 1, 0);
        @(negedge clk);
        chk("sim_first_addr", mem_if.addr, 32'h0000_3000);
        chk("sim_first_inst_aok", inst_if.addr_ok, 0);
        nxt();
        drv(1, 0, 1, 0);
        @(negedge clk);
        chk("sim_second_aok", inst_if.addr_ok, 1);
        nxt();
        drv(0, 0, 0, 1);
        mem_if.rdata = 32'h1111_1111;
        @(negedge clk);
        chk("sim_ret1_data", data_if.data_ok, 1);
        chk("sim_ret1_inst", inst_if.data_ok, 0);
        nxt();
        mem_if.rdata = 32'h2222_2222;
        @(negedge clk);
        chk("sim_ret2_inst", inst_if.data_ok, 1);
        chk("sim_ret2_rdata", inst_if.rdata, 32'h2222_2222);
        nxt();

        // full FIFO
        drv(1, 0, 1, 0);
        nxt();
        nxt();
        @(negedge clk);
        chk("full_block1", mem_if.req, 0);
        nxt();
        @(negedge clk);
        chk("full_block2", mem_if.req, 0);
        nxt();
        drv(1, 0, 1, 1);
        @(negedge clk);
        chk("full_pop_cycle", mem_if.req, 0);
        chk("full_pop_dok", inst_if.data_ok, 1);
        nxt();
        drv(1, 0, 1, 0);
        @(negedge clk);
        chk("full_reissue", mem_if.req, 1);
        nxt();
        drv(0, 0, 0, 1);
        nxt();
        nxt();
        drv(0, 0, 0, 0);
        nxt();

        // spurious response
        drv(0, 0, 0, 1);
        @(negedge clk);
        chk("spur_inst_dok", inst_if.data_ok, 0);
        chk("spur_data_dok", data_if.data_ok, 0);
        nxt();
        drv(0, 1, 1, 0);
        nxt();
        drv(1, 0, 1, 0);
        @(negedge clk);
        chk("spur_count_ok", mem_if.req, 1);
        nxt();
        drv(1, 0, 1, 0);
        @(negedge clk);
        chk("spur_full_after2", mem_if.req, 0);
        nxt();
        drv(0, 0, 0, 1);
        @(negedge clk);
        chk("spur_ret_data", data_if.data_ok, 1);
        nxt();
        @(negedge clk);
        chk("spur_ret_inst", inst_if.data_ok, 1);
        nxt();
        drv(0, 0, 0, 0);
        nxt();

        // reset mid-transaction
        drv(1, 0, 1, 0);
        nxt();
        drv(0, 1, 0, 0);
        nxt();
        resetn = 0;
        drv(0, 1, 0, 1);
        @(negedge clk);
        chk("mr_mem_req", mem_if.req, 0);
        chk("mr_data_dok", data_if.data_ok, 0);
        chk("mr_inst_dok", inst_if.data_ok, 0);
        nxt();
        resetn = 1;
        drv(1, 0, 1, 1);
        @(negedge clk);
        chk("mr_stray_inst", inst_if.data_ok, 0);
        chk("mr_stray_data", data_if.data_ok, 0);
        chk("mr_lock_clear", mem_if.req, 1);
        chk("mr_lock_addr", mem_if.addr, inst_if.addr);
        nxt();
        drv(0, 0, 0, 1);
        @(negedge clk);
        chk("mr_after_ret", inst_if.data_ok, 1);
        nxt();
        drv(0, 0, 0, 0);
        nxt();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
